// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the fetch PC and the IDLE/RUN/FLUSH/HALT run state.
// Optional single-step gating is compiled in when STEP_MODE_EN is defined.
module fetch_sequencer #(
  parameter int                PC_W         = 10,
  parameter int                INSTR_W      = 32,
  parameter logic [5:0]        HALT_OPCODE  = 6'b111111,
  parameter int                FLUSH_CYCLES = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic [INSTR_W-1:0] instr_in,
`ifdef STEP_MODE_EN
  input  logic               step_en,
  input  logic               step_req,
`endif
  output logic [PC_W-1:0]    fetch_pc,
  output logic               flush,
  output logic               running,
  output logic               halted,
  output logic [15:0]        fetch_count,
  output logic [15:0]        stall_count
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, HALT} state_t;

  localparam logic [2:0]         FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  // Opcode compare done on the whole word so every instruction bit is consumed.
  localparam logic [INSTR_W-1:0] OP_MASK    = {6'h3F, {(INSTR_W-6){1'b0}}};
  localparam logic [INSTR_W-1:0] HALT_WORD  = {HALT_OPCODE, {(INSTR_W-6){1'b0}}};

  state_t     state;
  logic [2:0] flush_cnt;
  logic       is_halt;
  logic       step_hold;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign is_halt = ((instr_in & OP_MASK) == HALT_WORD);

`ifdef STEP_MODE_EN
  assign step_hold = step_en && !step_req;
`else
  assign step_hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      fetch_pc    <= '0;
      flush       <= 1'b0;
      running     <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
      stall_count <= '0;
      flush_cnt   <= '0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (start) begin
            state       <= RUN;
            fetch_pc    <= '0;
            running     <= 1'b1;
            halted      <= 1'b0;
            fetch_count <= '0;
            stall_count <= '0;
          end
        end
        RUN, FLUSH: begin
          if (redirect_valid) begin
            state       <= FLUSH;
            fetch_pc    <= redirect_pc;
            flush       <= 1'b1;
            flush_cnt   <= FLUSH_INIT;
            fetch_count <= sat_inc(fetch_count);
          end else if (state == RUN && is_halt) begin
            // During FLUSH instr_in is wrong-path, so halt is only honoured in RUN.
            state   <= HALT;
            running <= 1'b0;
            halted  <= 1'b1;
          end else if (stall) begin
            stall_count <= sat_inc(stall_count);
          end else if (!step_hold) begin
            fetch_pc    <= fetch_pc + PC_W'(1);
            fetch_count <= sat_inc(fetch_count);
            if (state == FLUSH) begin
              if (flush_cnt == 3'd0) begin
                state <= RUN;
                flush <= 1'b0;
              end else begin
                flush_cnt <= flush_cnt - 3'd1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed scoreboard bench for fetch_sequencer (built with FLUSH_CYCLES=2).
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [9:0]  redirect_pc = '0;
  logic [31:0] instr_in = '0;
  logic [9:0]  fetch_pc;
  logic        flush, running, halted;
  logic [15:0] fetch_count, stall_count;
`ifdef STEP_MODE_EN
  logic        step_en = 1'b0;
  logic        step_req = 1'b0;
`endif

  fetch_sequencer #(
    .PC_W(10), .INSTR_W(32), .HALT_OPCODE(6'b111111), .FLUSH_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .instr_in(instr_in),
`ifdef STEP_MODE_EN
    .step_en(step_en), .step_req(step_req),
`endif
    .fetch_pc(fetch_pc), .flush(flush), .running(running), .halted(halted),
    .fetch_count(fetch_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  pc;
    logic        fl;
    logic        run;
    logic        hlt;
    logic [15:0] fc;
    logic [15:0] sc;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  localparam logic [31:0] HALT_I = 32'hFC00_0000;
  localparam logic [31:0] NOP_I  = 32'h0000_0013;

  // One clock of stimulus; expectation describes outputs after the coming edge.
  task automatic cyc(input logic rs, input logic st, input logic sl, input logic rv,
                     input logic [9:0] rpc, input logic [31:0] ins,
                     input logic [9:0] e_pc, input logic e_fl, input logic e_run,
                     input logic e_hlt, input logic [15:0] e_fc, input logic [15:0] e_sc,
                     input string nm);
    exp_t e;
    @(negedge clk);
    reset = rs; start = st; stall = sl; redirect_valid = rv;
    redirect_pc = rpc; instr_in = ins;
    e = '{pc: e_pc, fl: e_fl, run: e_run, hlt: e_hlt, fc: e_fc, sc: e_sc};
    @(posedge clk);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: compares the registered outputs half a cycle after each edge.
  initial begin
    exp_t  e;
    exp_t  a;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = '{pc: fetch_pc, fl: flush, run: running, hlt: halted,
               fc: fetch_count, sc: stall_count};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL %s: got pc=%h flush=%b run=%b halt=%b fc=%0d sc=%0d, want pc=%h flush=%b run=%b halt=%b fc=%0d sc=%0d",
                   nm, a.pc, a.fl, a.run, a.hlt, a.fc, a.sc,
                   e.pc, e.fl, e.run, e.hlt, e.fc, e.sc);
        end
      end
    end
  end

  initial begin
    // reset and idle behaviour
    cyc(1,0,0,0,10'h000,NOP_I, 10'h000,0,0,0,0,0, "reset");
    cyc(1,1,1,1,10'h123,NOP_I, 10'h000,0,0,0,0,0, "reset_over_start");
    cyc(0,0,1,1,10'h123,NOP_I, 10'h000,0,0,0,0,0, "idle_ignores");
    // start, free-running advance to pc 8
    cyc(0,1,0,0,10'h000,NOP_I, 10'h000,0,1,0,0,0, "start");
    for (int i = 1; i <= 8; i++)
      cyc(0,0,0,0,10'h000,NOP_I, 10'(i),0,1,0,16'(i),0, "advance");
    // stall three cycles at pc 8
    for (int i = 1; i <= 3; i++)
      cyc(0,0,1,0,10'h000,NOP_I, 10'h008,0,1,0,8,16'(i), "stall_hold");
    cyc(0,0,0,0,10'h000,NOP_I, 10'h009,0,1,0,9,3, "after_stall");
    // redirect beats stall; halt opcode ignored while flushing
    cyc(0,0,1,1,10'h3F0,NOP_I,  10'h3F0,1,1,0,10,3, "redirect_stall");
    cyc(0,0,0,0,10'h000,HALT_I, 10'h3F1,1,1,0,11,3, "flush_ignore_halt1");
    cyc(0,0,0,0,10'h000,HALT_I, 10'h3F2,0,1,0,12,3, "flush_end_run");
    // wrap 3FF -> 000 in RUN
    cyc(0,0,0,1,10'h3FC,NOP_I, 10'h3FC,1,1,0,13,3, "redirect_3fc");
    cyc(0,0,0,0,10'h000,NOP_I, 10'h3FD,1,1,0,14,3, "flush_adv");
    cyc(0,0,0,0,10'h000,NOP_I, 10'h3FE,0,1,0,15,3, "flush_done");
    cyc(0,0,0,0,10'h000,NOP_I, 10'h3FF,0,1,0,16,3, "to_max");
    cyc(0,0,0,0,10'h000,NOP_I, 10'h000,0,1,0,17,3, "wrap");
    // stall inside FLUSH holds pc and flush counter
    cyc(0,0,0,1,10'h012,NOP_I, 10'h012,1,1,0,18,3, "redirect_012");
    cyc(0,0,1,0,10'h000,NOP_I, 10'h012,1,1,0,18,4, "flush_stall");
    cyc(0,0,0,0,10'h000,NOP_I, 10'h013,1,1,0,19,4, "flush_adv2");
    cyc(0,0,0,0,10'h000,NOP_I, 10'h014,0,1,0,20,4, "flush_done2");
    // halt at pc 20, redirect ignored, restart from 0
    cyc(0,0,0,0,10'h000,HALT_I, 10'h014,0,0,1,20,4, "halt");
    cyc(0,0,1,1,10'h2AA,HALT_I, 10'h014,0,0,1,20,4, "halt_ignores");
    cyc(0,1,0,0,10'h000,NOP_I,  10'h000,0,1,0,0,0,  "restart");
    cyc(0,0,0,0,10'h000,NOP_I,  10'h001,0,1,0,1,0,  "restart_adv");
    // redirect during FLUSH reloads target and restarts flush counter
    cyc(0,0,0,1,10'h100,NOP_I, 10'h100,1,1,0,2,0, "redirect_100");
    cyc(0,0,0,1,10'h200,NOP_I, 10'h200,1,1,0,3,0, "redirect_in_flush");
    cyc(0,0,0,0,10'h000,NOP_I, 10'h201,1,1,0,4,0, "reflush_adv");
    cyc(0,0,0,0,10'h000,NOP_I, 10'h202,0,1,0,5,0, "reflush_done");
    cyc(0,1,0,0,10'h000,NOP_I, 10'h203,0,1,0,6,0, "start_in_run");
    // redirect outranks halt opcode; then reset mid-flush
    cyc(0,0,0,1,10'h050,HALT_I, 10'h050,1,1,0,7,0, "redirect_over_halt");
    cyc(0,0,0,0,10'h000,NOP_I,  10'h051,1,1,0,8,0, "flush_adv3");
    cyc(1,0,0,1,10'h077,NOP_I,  10'h000,0,0,0,0,0, "reset_in_flush");
    cyc(0,0,0,0,10'h000,NOP_I,  10'h000,0,0,0,0,0, "idle_after_reset");
    cyc(0,1,0,0,10'h000,NOP_I,  10'h000,0,1,0,0,0, "start_again");
    cyc(0,0,0,0,10'h000,NOP_I,  10'h001,0,1,0,1,0, "adv_again");

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Sequencer for the instruction fetch stage. Owns the fetch PC and the pipeline run state, and resolves stall, redirect (branch/jump) and halt requests into one PC per cycle plus a flush strobe for the IF/ID boundary. Updates on posedge clk, so fetch_pc is stable before the fetch stage samples on negedge.

Parameters:
PC_W, 10, width of fetch PC (instruction-word address)
INSTR_W, 32, width of fetched instruction
HALT_OPCODE, 6'b111111, value of instr_in[31:26] that halts fetch
FLUSH_CYCLES, 1, cycles flush stays asserted after an accepted redirect (1..7)

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  synchronous, active-high
start  in  1  begin fetching from PC 0 (IDLE or HALT only)
stall  in  1  hazard-unit hold request
redirect_valid  in  1  taken branch/jump this cycle
redirect_pc  in  PC_W  redirect target
instr_in  in  INSTR_W  instruction currently returned by fetch stage
fetch_pc  out  PC_W  PC presented to fetch stage current-PC input
flush  out  1  IF/ID must insert a bubble
running  out  1  state is RUN or FLUSH
halted  out  1  state is HALT
fetch_count  out  16  fetches issued since start, saturating
stall_count  out  16  stall cycles since start, saturating

Behaviour:
- Reset (sync, highest priority, any state incl. mid-flush): state=IDLE, fetch_pc=0, flush=0, running=0, halted=0, fetch_count=0, stall_count=0, flush counter=0.
- States: IDLE, RUN, FLUSH, HALT. All outputs registered.
- IDLE: start=1 -> RUN, fetch_pc=0, counters cleared. stall/redirect ignored.
- RUN, priority per cycle: redirect > halt > stall > advance.
  - redirect_valid=1: fetch_pc<=redirect_pc, flush<=1, flush counter<=FLUSH_CYCLES-1, ->FLUSH (if FLUSH_CYCLES=1, FLUSH lasts one cycle); fetch_count+1. Stall ignored that cycle.
  - instr_in[31:26]==HALT_OPCODE: ->HALT, fetch_pc holds, running<=0, halted<=1.
  - stall=1: fetch_pc holds, stall_count+1, fetch_count unchanged.
  - else: fetch_pc<=fetch_pc+1 modulo 2^PC_W (max value wraps to 0, no flag), fetch_count+1.
- FLUSH: flush=1; halt detection suppressed (instr_in is wrong-path).
  - redirect_valid=1: same as RUN redirect (target reloaded, counter restarted).
  - stall=1: fetch_pc and flush counter hold, stall_count+1, flush stays 1.
  - else: fetch_pc+1 (wrap), fetch_count+1; counter==0 -> RUN with flush<=0, else counter-1.
- HALT: fetch_pc frozen, halted=1; stall/redirect ignored; start=1 -> RUN at PC 0, halted<=0, counters cleared.
- start while RUN/FLUSH: ignored.
- Counters saturate at 16'hFFFF.

Optional Feature:
STEP_MODE_EN: adds inputs step_en (1) and step_req (1). In RUN/FLUSH with step_en=1 and no redirect, fetch advances only on cycles with step_req=1; other cycles hold exactly like stall but do NOT increment stall_count; redirect and halt still take effect regardless of step_req. Macro undefined: ports absent, fetch advances every non-stalled cycle.

Test Plan:
- reset, start pulse, 5 idle cycles -> fetch_pc 0,1,2,3,4,5; fetch_count=5; flush=0; running=1.
- RUN at pc 8, stall high 3 cycles -> fetch_pc holds 8 for 3 cycles, stall_count=3, then 9.
- RUN, redirect_valid with redirect_pc=10'h3F0 and stall=1 same cycle, FLUSH_CYCLES=2 -> fetch_pc=3F0, flush=1 for 2 cycles, instr_in=FC000000 ignored during flush, then RUN at 3F2.
- fetch_pc=10'h3FF, advance -> fetch_pc=0, no halt, fetch_count incremented.
- instr_in=32'hFC000000 in RUN at pc 20 -> HALT next edge, halted=1, fetch_pc stays 20; redirect ignored; start -> RUN at 0, counters 0.
- reset asserted in FLUSH -> next edge IDLE, flush=0, all outputs 0; start required to resume.
